sensor_event_arbiter: RTL
=========================

# sensor_event_arbiter

Shares the single actuator/display output bank of the home-automation controller between the six sensor event sources. Each request is latched as pending, then granted exclusively for a fixed dwell. Grants follow round-robin order, with a one-cycle guard gap between grants. The block replaces fixed time-slot polling: idle sources cost no output time, and every asserted source is served within a bounded wait.

## Interface
- HOLD_CYCLES, 8, grant dwell in Clk cycles (≥1)
- TEMP_LO, 50, low-temperature threshold (strict less-than raises the heater request)
- TEMP_HI, 70, high-temperature threshold (strict greater-than raises the cooler request)

- Clk  input  1  clock; all state updates on the falling edge
- Rst  input  1  reset; synchronous, active-high
- SFD, SRD, SFA, SW  input  1 each  front door, rear door, fire alarm, window sensors (level)
- ST  input  7  temperature, unsigned
- Ack  input  1  early release of the current grant
- fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler  output  1 each  one-hot actuator drive
- display  output  3  code of the granted source; 0 when none is granted
- busy  output  1  high while in SERVE
- pending  output  6  latched requests, indices 0..5

## Operation
- Source index / actuator / display code:
  - 0 SFD / fdoor / 1
  - 1 SRD / rdoor / 2
  - 2 SFA / alarmbuzz / 3
  - 3 SW / winbuzz / 4
  - 4 ST<TEMP_LO / heater / 5
  - 5 ST>TEMP_HI / cooler / 6
- Request vector req[5:0] is evaluated every edge. pending[i] is set when req[i]=1.
- pending[i] clears when source i's grant ends normally or by Ack. On that edge clear beats set; a still-asserted request re-latches on the next edge.
- States:
  - IDLE: outputs 0. If pending≠0, pick a source, load the counter with HOLD_CYCLES-1, go to SERVE.
  - SERVE: drive the granted actuator and its display code. Counter decrements each edge. At counter=0, or when Ack=1, clear the granted pending bit and go to GAP.
  - GAP: outputs 0 for exactly one cycle. If pending≠0, pick a source and go to SERVE; otherwise go to IDLE.
- Pick rule: first set pending bit searching upward from rr_ptr, wrapping 5→0. rr_ptr becomes granted index+1 (mod 6). rr_ptr resets to 0.
- Counter width is $clog2(HOLD_CYCLES+1). HOLD_CYCLES=1 gives a single-cycle grant.
- Reset values: state IDLE; all actuators 0; display 0; busy 0; pending 0; rr_ptr 0.
- Rst overrides Ack and all requests, including mid-SERVE.

## Timing
- Request sampled at edge n → pending at edge n → grant outputs valid from edge n+1.
- Grant lasts exactly HOLD_CYCLES cycles unless released by Ack.
- Ack seen at edge m during SERVE → outputs 0 after edge m.
- Back-to-back grants repeat every HOLD_CYCLES+1 cycles.
- Worst-case wait for a pending source: 5·(HOLD_CYCLES+1) cycles.
- TEMP boundaries: ST=TEMP_LO and ST=TEMP_HI raise no request. Heater and cooler requests are mutually exclusive.

## Configuration
- FIRE_PREEMPT_EN defined:
  - In SERVE with grant≠2 and pending[2]=1, go to GAP on the next edge. The preempted source's pending bit stays set and rr_ptr is unchanged.
  - Arbitration in GAP and IDLE grants index 2 whenever it is pending, regardless of rr_ptr.
- FIRE_PREEMPT_EN undefined: pure round-robin; fire waits its turn.

## Structure
- Package home_auto_pkg:
  - state enum (IDLE, SERVE, GAP)
  - source index localparams
  - display codes 1..6
  - TEMP_LO/TEMP_HI defaults
- Sub-module rr_pick: combinational 6-bit round-robin priority encoder. Inputs: pending, rr_ptr. Outputs: valid, index.

## Test plan
- Reset: Rst=1 for 2 cycles with all sensors=1 and ST=100 → all outputs 0, pending=0, busy=0. Release Rst → fdoor grant first.
- HOLD_CYCLES=4, SFD pulsed 1 cycle, ST=60 → pending[0] set; fdoor=1 and display=1 for 4 cycles; one gap cycle of 0s; IDLE.
- SRD and SW held, ST=60 → rdoor/2 for 4 cycles, gap, winbuzz/4 for 4 cycles, gap, rdoor/2 again.
- ST sweep:
  - 40 → heater/5
  - 75 → cooler/6
  - 50 and 70 → no grant
- Ack on the 2nd SERVE cycle of an SRD grant → outputs 0 on the next edge; pending[1] clears; next pending source is granted after one gap cycle.
- SFD serving at cycle 2, SFA rises:
  - With FIRE_PREEMPT_EN: gap, then alarmbuzz/3 for 4 cycles, then fdoor resumes.
  - Without FIRE_PREEMPT_EN: fdoor finishes all 4 cycles, then alarmbuzz.

Source files
------------

// File: rtl/home_auto_pkg.sv
// Shared types and constants for the home-automation sensor arbiter.
// Source indices, display codes and default temperature thresholds live here.
package home_auto_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [2:0] SRC_FDOOR  = 3'd0;
  localparam logic [2:0] SRC_RDOOR  = 3'd1;
  localparam logic [2:0] SRC_FIRE   = 3'd2;
  localparam logic [2:0] SRC_WINDOW = 3'd3;
  localparam logic [2:0] SRC_HEAT   = 3'd4;
  localparam logic [2:0] SRC_COOL   = 3'd5;

  localparam logic [2:0] DISP_NONE   = 3'd0;
  localparam logic [2:0] DISP_FDOOR  = 3'd1;
  localparam logic [2:0] DISP_RDOOR  = 3'd2;
  localparam logic [2:0] DISP_FIRE   = 3'd3;
  localparam logic [2:0] DISP_WINDOW = 3'd4;
  localparam logic [2:0] DISP_HEAT   = 3'd5;
  localparam logic [2:0] DISP_COOL   = 3'd6;

  localparam int unsigned TEMP_LO_DEF = 50;
  localparam int unsigned TEMP_HI_DEF = 70;

  // Round-robin successor, wrapping the last source back to the first.
  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx >= SRC_COOL) ? SRC_FDOOR : idx + 3'd1;
  endfunction

  function automatic logic [5:0] src_onehot(input logic [2:0] idx);
    return 6'd1 << idx;
  endfunction

  function automatic logic [2:0] disp_code(input logic [2:0] idx);
    case (idx)
      SRC_FDOOR:  return DISP_FDOOR;
      SRC_RDOOR:  return DISP_RDOOR;
      SRC_FIRE:   return DISP_FIRE;
      SRC_WINDOW: return DISP_WINDOW;
      SRC_HEAT:   return DISP_HEAT;
      SRC_COOL:   return DISP_COOL;
      default:    return DISP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sensor_event_arbiter_rr_pick.sv
// Combinational 6-way round-robin priority encoder: first pending bit at or
// above rr_ptr, wrapping from the last source back to the first.
module rr_pick
  import home_auto_pkg::*;
(
  input  logic [5:0] pending,
  input  logic [2:0] rr_ptr,
  output logic       valid,
  output logic [2:0] index
);

  always_comb begin
    logic [2:0] cand;
    valid = 1'b0;
    index = rr_ptr;
    cand  = rr_ptr;
    for (int k = 0; k < 6; k++) begin
      if (!valid && (|(pending & src_onehot(cand)))) begin
        valid = 1'b1;
        index = cand;
      end
      cand = next_idx(cand);
    end
  end

endmodule

// File: rtl/sensor_event_arbiter.sv
// Grants the shared actuator/display bank to one latched sensor event at a time,
// round-robin, with a fixed dwell and a one-cycle guard gap between grants.
// Optional FIRE_PREEMPT_EN: fire alarm preempts other grants and wins arbitration.
//
// state | meaning
// IDLE  | nothing granted, nothing pending last edge
// SERVE | one source owns the outputs, dwell counter running
// GAP   | one guard cycle with outputs low before the next grant
module sensor_event_arbiter
  import home_auto_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned TEMP_LO     = TEMP_LO_DEF,
  parameter int unsigned TEMP_HI     = TEMP_HI_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SFA,
  input  logic       SW,
  input  logic [6:0] ST,
  input  logic       Ack,
  output logic       fdoor,
  output logic       rdoor,
  output logic       alarmbuzz,
  output logic       winbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic       busy,
  output logic [5:0] pending
);

  localparam int unsigned     CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(HOLD_CYCLES - 1);

  state_t        state;
  logic [2:0]    rr_ptr;
  logic [2:0]    gidx;
  logic [CW-1:0] cnt;
  logic [5:0]    act;

  logic [5:0]    req;
  logic          rr_valid;
  logic [2:0]    rr_index;
  logic          pick_valid;
  logic [2:0]    pick_idx;
  logic          preempt;
  logic          grant_end;
  logic [5:0]    clr_mask;

  // Strict compares: the thresholds themselves raise no request.
  assign req = {ST > 7'(TEMP_HI), ST < 7'(TEMP_LO), SW, SFA, SRD, SFD};

  rr_pick u_rr_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .valid   (rr_valid),
    .index   (rr_index)
  );

`ifdef FIRE_PREEMPT_EN
  assign pick_valid = rr_valid;
  assign pick_idx   = pending[SRC_FIRE] ? SRC_FIRE : rr_index;
  assign preempt    = (gidx != SRC_FIRE) && pending[SRC_FIRE];
`else
  assign pick_valid = rr_valid;
  assign pick_idx   = rr_index;
  assign preempt    = 1'b0;
`endif

  // A preempted grant keeps its pending bit; only normal end or Ack clears it.
  assign grant_end = (state == SERVE) && ((cnt == '0) || Ack);
  assign clr_mask  = grant_end ? src_onehot(gidx) : 6'd0;

  always_ff @(negedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      rr_ptr  <= 3'd0;
      gidx    <= 3'd0;
      cnt     <= '0;
      act     <= 6'd0;
      display <= DISP_NONE;
      busy    <= 1'b0;
      pending <= 6'd0;
    end else begin
      pending <= (pending | req) & ~clr_mask;
      case (state)
        IDLE, GAP: begin
          if (pick_valid) begin
            state   <= SERVE;
            gidx    <= pick_idx;
            rr_ptr  <= next_idx(pick_idx);
            cnt     <= CNT_LOAD;
            act     <= src_onehot(pick_idx);
            display <= disp_code(pick_idx);
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        SERVE: begin
          if (grant_end || preempt) begin
            state   <= GAP;
            act     <= 6'd0;
            display <= DISP_NONE;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          act     <= 6'd0;
          display <= DISP_NONE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign fdoor     = act[0];
  assign rdoor     = act[1];
  assign alarmbuzz = act[2];
  assign winbuzz   = act[3];
  assign heater    = act[4];
  assign cooler    = act[5];

endmodule
